sccb_master: RTL and testbench

SCCB_MASTER -- requirements
Module: sccb_master

---
 rtl/sccb_master.sv | 252 +++++++++++++++++++++++++
 tb/tb_sccb_master.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_master.sv
// SCCB (I2C-like) master for camera register access, quarter-tick bus timing.
// Ports: clk/reset/tick, start+rw+devAddr+regAddr+wrData request,
//        busy/done/ackErr/rdData status, sccbClock/sdaOut/sdaIn pad side.
module sccb_master #(
    parameter bit CHECK_ACK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] devAddr,
    input  logic [7:0] regAddr,
    input  logic [7:0] wrData,
    output logic       busy,
    output logic       done,
    output logic       ackErr,
    output logic [7:0] rdData,
    output logic       sccbClock,
    output logic       sdaOut,
    input  logic       sdaIn
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        SEND,
        ACK,
        RECV,
        MNACK,
        STOP
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] qcnt_q, qcnt_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [1:0] byte_q, byte_d;
    logic       phase_q, phase_d;
    logic       rw_q, rw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wr_q, wr_d;
    logic [7:0] rx_q, rx_d;
    logic       ackErr_q, ackErr_d;
    logic [7:0] rdData_q, rdData_d;
    logic       done_q, done_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;

    logic [7:0] tx_byte;
    logic       tx_bit;
    logic       seg_scl;
    logic       seg_sda;
    logic       mid;
    logic       last_q;

    // Byte 0 carries the R/W bit; it is only 1 in the second read phase.
    always_comb begin
        tx_byte = wr_q;
        unique case (byte_q)
            2'd0:    tx_byte = {dev_q, phase_q};
            2'd1:    tx_byte = reg_q;
            default: tx_byte = wr_q;
        endcase
    end

    assign tx_bit = tx_byte[bitcnt_q];
    assign mid    = qcnt_q[0] ^ qcnt_q[1];
    assign last_q = (qcnt_q == 2'd3);

    // Bus level for the current segment quarter.
    always_comb begin
        seg_scl = 1'b1;
        seg_sda = 1'b1;
        unique case (state_q)
            START: begin
                seg_scl = (qcnt_q != 2'd3);
                seg_sda = ~qcnt_q[1];
            end
            SEND: begin
                seg_scl = mid;
                seg_sda = tx_bit;
            end
            ACK, RECV, MNACK: begin
                seg_scl = mid;
                seg_sda = 1'b1;
            end
            STOP: begin
                seg_scl = (qcnt_q != 2'd0);
                seg_sda = qcnt_q[1];
            end
            default: begin
                seg_scl = 1'b1;
                seg_sda = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        qcnt_d   = qcnt_q;
        bitcnt_d = bitcnt_q;
        byte_d   = byte_q;
        phase_d  = phase_q;
        rw_d     = rw_q;
        dev_d    = dev_q;
        reg_d    = reg_q;
        wr_d     = wr_q;
        rx_d     = rx_q;
        ackErr_d = ackErr_q;
        rdData_d = rdData_q;
        done_d   = 1'b0;
        scl_d    = scl_q;
        sda_d    = sda_q;

        if (state_q == IDLE) begin
            scl_d = 1'b1;
            sda_d = 1'b1;
            if (start) begin
                state_d  = START;
                qcnt_d   = 2'd0;
                bitcnt_d = 3'd7;
                byte_d   = 2'd0;
                phase_d  = 1'b0;
                rw_d     = rw;
                dev_d    = devAddr;
                reg_d    = regAddr;
                wr_d     = wrData;
                ackErr_d = 1'b0;
            end
        end else if (tick) begin
            scl_d  = seg_scl;
            sda_d  = seg_sda;
            qcnt_d = qcnt_q + 2'd1;
            unique case (state_q)
                START: begin
                    if (last_q) begin
                        state_d  = SEND;
                        bitcnt_d = 3'd7;
                    end
                end
                SEND: begin
                    if (last_q) begin
                        if (bitcnt_q == 3'd0) begin
                            state_d = ACK;
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end
                ACK: begin
                    if (qcnt_q == 2'd2 && CHECK_ACK && sdaIn) begin
                        ackErr_d = 1'b1;
                    end
                    if (last_q) begin
                        // Abort, end of write, or end of read phase 1.
                        if (ackErr_q || byte_q == 2'd2 ||
                            (rw_q && !phase_q && byte_q == 2'd1)) begin
                            state_d = STOP;
                        end else if (rw_q && phase_q) begin
                            state_d  = RECV;
                            bitcnt_d = 3'd7;
                        end else begin
                            state_d  = SEND;
                            bitcnt_d = 3'd7;
                            byte_d   = byte_q + 2'd1;
                        end
                    end
                end
                RECV: begin
                    if (qcnt_q == 2'd2) begin
                        rx_d = {rx_q[6:0], sdaIn};
                    end
                    if (last_q) begin
                        if (bitcnt_q == 3'd0) begin
                            state_d = MNACK;
                        end else begin
                            bitcnt_d = bitcnt_q - 3'd1;
                        end
                    end
                end
                MNACK: begin
                    if (last_q) begin
                        state_d = STOP;
                    end
                end
                STOP: begin
                    if (last_q) begin
                        if (rw_q && !phase_q && !ackErr_q) begin
                            state_d = START;
                            phase_d = 1'b1;
                            byte_d  = 2'd0;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            if (rw_q && !ackErr_q) begin
                                rdData_d = rx_q;
                            end
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            qcnt_q   <= 2'd0;
            bitcnt_q <= 3'd0;
            byte_q   <= 2'd0;
            phase_q  <= 1'b0;
            rw_q     <= 1'b0;
            dev_q    <= 7'd0;
            reg_q    <= 8'd0;
            wr_q     <= 8'd0;
            rx_q     <= 8'd0;
            ackErr_q <= 1'b0;
            rdData_q <= 8'd0;
            done_q   <= 1'b0;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            qcnt_q   <= qcnt_d;
            bitcnt_q <= bitcnt_d;
            byte_q   <= byte_d;
            phase_q  <= phase_d;
            rw_q     <= rw_d;
            dev_q    <= dev_d;
            reg_q    <= reg_d;
            wr_q     <= wr_d;
            rx_q     <= rx_d;
            ackErr_q <= ackErr_d;
            rdData_q <= rdData_d;
            done_q   <= done_d;
            scl_q    <= scl_d;
            sda_q    <= sda_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign ackErr    = ackErr_q;
    assign rdData    = rdData_q;
    assign sccbClock = scl_q;
    assign sdaOut    = sda_q;

endmodule

// File: tb/tb_sccb_master.sv
// Self-checking bench for sccb_master: two instances (CHECK_ACK 1 and 0)
// driven identically and compared every cycle against a waveform model.
module tb_sccb_master;

    logic       clk = 1'b0;
    logic       reset, tick, start, rw;
    logic [6:0] devAddr;
    logic [7:0] regAddr, wrData;
    logic [1:0] busy, done, ackErr, scl, sdaO, sdaI;
    logic [1:0] slv_rel;
    logic [7:0] rdData0, rdData1;

    always #5 clk = ~clk;

    assign sdaI = sdaO & slv_rel;

    sccb_master #(.CHECK_ACK(1'b1)) u_chk (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .rw(rw),
        .devAddr(devAddr), .regAddr(regAddr), .wrData(wrData),
        .busy(busy[0]), .done(done[0]), .ackErr(ackErr[0]),
        .rdData(rdData0), .sccbClock(scl[0]), .sdaOut(sdaO[0]),
        .sdaIn(sdaI[0]));

    sccb_master #(.CHECK_ACK(1'b0)) u_nochk (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .rw(rw),
        .devAddr(devAddr), .regAddr(regAddr), .wrData(wrData),
        .busy(busy[1]), .done(done[1]), .ackErr(ackErr[1]),
        .rdData(rdData1), .sccbClock(scl[1]), .sdaOut(sdaO[1]),
        .sdaIn(sdaI[1]));

    // Expected quarter-by-quarter waveform plus slave drive per instance.
    bit         m_scl [2][200];
    bit         m_sda [2][200];
    bit         m_sl  [2][200];
    int         m_len [2];
    bit         m_err [2];
    bit         m_upd [2];
    logic [7:0] m_rdv [2];

    bit         act   [2];
    int         k     [2];
    bit         e_done[2];
    bit         e_err [2];
    logic [7:0] e_rd  [2];
    int         ndone [2];
    int         acc_cyc [2];
    int         done_cyc[2];
    logic [1:0] pscl, psda;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int tmode = 0;
    int tph   = 0;

    task automatic chk(string nm, int d, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)",
                     nm, d, a, e, cyc);
        end
    endtask

    task automatic push(int d, bit c, bit s, bit sl);
        m_scl[d][m_len[d]] = c;
        m_sda[d][m_len[d]] = s;
        m_sl[d][m_len[d]]  = sl;
        m_len[d]++;
    endtask

    task automatic seg_start(int d);
        push(d, 1, 1, 1); push(d, 1, 1, 1);
        push(d, 1, 0, 1); push(d, 0, 0, 1);
    endtask

    task automatic seg_stop(int d);
        push(d, 0, 0, 1); push(d, 1, 0, 1);
        push(d, 1, 1, 1); push(d, 1, 1, 1);
    endtask

    task automatic seg_bit(int d, bit v, bit sl);
        push(d, 0, v, sl); push(d, 1, v, sl);
        push(d, 1, v, sl); push(d, 0, v, sl);
    endtask

    task automatic send(int d, logic [7:0] b, bit nack, output bit ab);
        for (int i = 7; i >= 0; i--) seg_bit(d, b[i], 1'b1);
        seg_bit(d, 1'b1, nack);
        ab = nack && (d == 0);
    endtask

    task automatic recv(int d, logic [7:0] v);
        for (int i = 7; i >= 0; i--) seg_bit(d, 1'b1, v[i]);
        seg_bit(d, 1'b1, 1'b1);
    endtask

    task automatic build(int d, bit r, logic [6:0] da, logic [7:0] ra,
                         logic [7:0] wd, logic [7:0] rv, logic [2:0] nk);
        bit ab;
        m_len[d] = 0;
        seg_start(d);
        send(d, {da, 1'b0}, nk[0], ab);
        if (!ab) send(d, ra, nk[1], ab);
        if (!ab) begin
            if (!r) begin
                send(d, wd, nk[2], ab);
            end else begin
                seg_stop(d);
                seg_start(d);
                send(d, {da, 1'b1}, nk[2], ab);
                if (!ab) recv(d, rv);
            end
        end
        seg_stop(d);
        m_err[d] = ab;
        m_upd[d] = r && !ab;
        m_rdv[d] = rv;
    endtask

    function automatic logic [7:0] mbyte(int d, int base);
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[7-i] = m_sda[d][base + 4*i + 2];
        return v;
    endfunction

    // Tick pattern generator.
    initial begin
        tick = 1'b0;
        forever begin
            @(negedge clk);
            case (tmode)
                0: tick = 1'b1;
                1: begin
                    tick = (tph == 0);
                    tph  = (tph + 1) % 4;
                end
                default: tick = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Model advance and per-cycle compare.
    initial begin
        bit r, t, s;
        bit xs, xd;
        pscl    = 2'b11;
        psda    = 2'b11;
        slv_rel = 2'b11;
        for (int d = 0; d < 2; d++) begin
            act[d] = 0; k[d] = 0; e_err[d] = 0; e_rd[d] = 8'h00;
            ndone[d] = 0; m_len[d] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            r = reset; t = tick; s = start;
            for (int d = 0; d < 2; d++) begin
                e_done[d] = 0;
                if (r) begin
                    act[d] = 0; k[d] = 0; e_err[d] = 0; e_rd[d] = 8'h00;
                end else if (!act[d]) begin
                    if (s) begin
                        act[d] = 1; k[d] = 0; e_err[d] = 0;
                        acc_cyc[d] = cyc;
                    end
                end else if (t) begin
                    k[d]++;
                    if (k[d] == m_len[d]) begin
                        act[d]    = 0;
                        e_done[d] = 1;
                        e_err[d]  = m_err[d];
                        if (m_upd[d]) e_rd[d] = m_rdv[d];
                    end
                end
            end
            #1;
            for (int d = 0; d < 2; d++) begin
                xs = (act[d] && k[d] > 0) ? m_scl[d][k[d]-1] : 1'b1;
                xd = (act[d] && k[d] > 0) ? m_sda[d][k[d]-1] : 1'b1;
                chk("busy", d, busy[d], act[d]);
                chk("done", d, done[d], e_done[d]);
                chk("scl", d, scl[d], xs);
                chk("sda", d, sdaO[d], xd);
                chk("rdData", d, (d == 0) ? rdData0 : rdData1, e_rd[d]);
                if (!act[d]) chk("ackErr", d, ackErr[d], e_err[d]);
                if (!t && !r) begin
                    chk("scl_hold", d, scl[d], pscl[d]);
                    chk("sda_hold", d, sdaO[d], psda[d]);
                end
                if (done[d]) begin
                    ndone[d]++;
                    done_cyc[d] = cyc;
                end
                slv_rel[d] = (act[d] && k[d] < m_len[d]) ? m_sl[d][k[d]] : 1'b1;
            end
            pscl = scl;
            psda = sdaO;
        end
    end

    task automatic wait_idle(string nm);
        int w = 0;
        while ((act[0] || act[1]) && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk(nm, 0, {30'd0, act[1], act[0]}, 0);
    endtask

    task automatic txn(bit r, logic [6:0] da, logic [7:0] ra, logic [7:0] wd,
                       logic [7:0] rv, logic [2:0] nk, int rst_at, bit dbl);
        int w;
        wait_idle("idle_wait");
        build(0, r, da, ra, wd, rv, nk);
        build(1, r, da, ra, wd, rv, nk);
        @(negedge clk);
        ndone[0] = 0; ndone[1] = 0;
        rw = r; devAddr = da; regAddr = ra; wrData = wd; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rw = 1'($urandom); devAddr = 7'($urandom);
        regAddr = 8'($urandom); wrData = 8'($urandom);
        if (dbl) begin
            repeat (10) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (rst_at >= 0) begin
            w = 0;
            while (k[0] < rst_at && w < 5000) begin
                @(negedge clk);
                w++;
            end
            chk("rst_wait", 0, (k[0] >= rst_at), 1);
            reset = 1'b1;
            start = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            start = 1'b0;
            @(negedge clk);
            chk("rst_scl", 0, scl[0], 1);
            chk("rst_sda", 0, sdaO[0], 1);
            chk("rst_busy", 0, busy[0], 0);
        end
        wait_idle("done_wait");
        for (int d = 0; d < 2; d++) chk("ndone", d, ndone[d], (rst_at >= 0) ? 0 : 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rw = 1'b0;
        devAddr = 7'd0; regAddr = 8'd0; wrData = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_rdData", 0, rdData0, 8'h00);
        chk("rst_ackErr", 0, ackErr[0], 0);

        // Directed write, tick every cycle.
        tmode = 0;
        txn(0, 7'h21, 8'h12, 8'h80, 8'h00, 3'b000, -1, 0);
        chk("w_len", 0, m_len[0], 116);
        chk("w_b0", 0, mbyte(0, 4), 8'h42);
        chk("w_b1", 0, mbyte(0, 40), 8'h12);
        chk("w_b2", 0, mbyte(0, 76), 8'h80);
        chk("w_lat", 0, done_cyc[0] - acc_cyc[0], 116);
        chk("w_ackErr", 0, ackErr[0], 0);

        // Directed read returning 0xA5.
        txn(1, 7'h21, 8'h0A, 8'h00, 8'hA5, 3'b000, -1, 0);
        chk("r_len", 0, m_len[0], 160);
        chk("r_b0", 0, mbyte(0, 4), 8'h42);
        chk("r_b2", 0, mbyte(0, 84), 8'h43);
        chk("r_lat", 0, done_cyc[0] - acc_cyc[0], 160);
        chk("r_data", 0, rdData0, 8'hA5);
        chk("r_data", 1, rdData1, 8'hA5);

        // NACK on device address.
        txn(0, 7'h21, 8'h12, 8'h80, 8'h00, 3'b001, -1, 0);
        chk("n_len", 0, m_len[0], 44);
        chk("n_lat", 0, done_cyc[0] - acc_cyc[0], 44);
        chk("n_lat", 1, done_cyc[1] - acc_cyc[1], 116);
        chk("n_ackErr", 0, ackErr[0], 1);
        chk("n_ackErr", 1, ackErr[1], 0);

        // Reset at tick 50 of a write, then a normal write.
        txn(0, 7'h30, 8'h55, 8'hAA, 8'h00, 3'b000, 50, 0);
        chk("rr_data", 0, rdData0, 8'h00);
        txn(0, 7'h21, 8'h12, 8'h80, 8'h00, 3'b000, -1, 0);

        // Sparse ticks with a second start while busy.
        tmode = 1;
        txn(1, 7'h3C, 8'h0A, 8'h00, 8'h5A, 3'b000, -1, 1);
        chk("s_lat", 0, done_cyc[0] - acc_cyc[0] >= 160 * 4 - 4, 1);

        // Randomized transactions.
        for (int n = 0; n < 24; n++) begin
            logic [2:0] nk;
            tmode = $urandom_range(0, 2);
            nk[0] = ($urandom_range(0, 5) == 0);
            nk[1] = ($urandom_range(0, 5) == 0);
            nk[2] = ($urandom_range(0, 5) == 0);
            txn(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), nk, -1, ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
